// File: rtl/cache.sv
// Direct-mapped cache storage array: 64 lines x 4 words x 32 bits, with a
// valid bit, dirty bit and 22-bit tag per line. Reads are combinational from
// addr; updates (fill, processor write, invalidate) happen on the rising edge.
//
// Ports:
//   clk      clock, all state updates on rising edge
//   rst      synchronous active-high reset; clears every line (data included)
//   addr     byte address: tag=[31:10], index=[9:4], word=[3:2]
//   store    line-fill write: word<=din, tag<=addr tag, valid=1, dirty=0
//   edit     processor write: word<=din, dirty=1, only when hit
//   invalid  invalidate addressed line (valid=0, dirty=0)
//   din      write data for store/edit
//   hit      addressed line valid and tag match
//   dout     stored word at (index, word), regardless of hit
//   valid    valid bit of indexed line
//   dirty    dirty bit of indexed line
//   tag      stored tag of indexed line
module cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        store,
  input  logic        edit,
  input  logic        invalid,
  input  logic [31:0] din,
  output logic        hit,
  output logic [31:0] dout,
  output logic        valid,
  output logic        dirty,
  output logic [21:0] tag
);

  localparam int LINES = 64;
  localparam int WORDS = 4;

  logic [LINES-1:0]                   valid_q;
  logic [LINES-1:0]                   dirty_q;
  logic [LINES-1:0][21:0]             tag_q;
  logic [LINES-1:0][WORDS-1:0][31:0]  data_q;

  logic [21:0] addr_tag;
  logic [5:0]  addr_idx;
  logic [1:0]  addr_wrd;

  assign addr_tag = addr[31:10];
  assign addr_idx = addr[9:4];
  assign addr_wrd = addr[3:2];

  // Zero-latency read path; writes only appear after the edge.
  assign valid = valid_q[addr_idx];
  assign dirty = dirty_q[addr_idx];
  assign tag   = tag_q[addr_idx];
  assign dout  = data_q[addr_idx][addr_wrd];
  assign hit   = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Strobe priority: invalid over store over edit.
  logic do_inv, do_store, do_edit;
  assign do_inv   = invalid;
  assign do_store = store && !invalid;
  assign do_edit  = edit && !store && !invalid && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (do_inv) begin
      valid_q[addr_idx] <= 1'b0;
      dirty_q[addr_idx] <= 1'b0;
    end else if (do_store) begin
      data_q[addr_idx][addr_wrd] <= din;
      tag_q[addr_idx]            <= addr_tag;
      valid_q[addr_idx]          <= 1'b1;
      dirty_q[addr_idx]          <= 1'b0;
    end else if (do_edit) begin
      data_q[addr_idx][addr_wrd] <= din;
      dirty_q[addr_idx]          <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache.sv
module tb_cache;
  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        store, edit, invalid;
  logic [31:0] din;
  logic        hit, valid, dirty;
  logic [31:0] dout;
  logic [21:0] tag;

  int checks = 0;
  int errors = 0;

  cache dut (
    .clk(clk), .rst(rst), .addr(addr), .store(store), .edit(edit),
    .invalid(invalid), .din(din), .hit(hit), .dout(dout), .valid(valid),
    .dirty(dirty), .tag(tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    store = 0; edit = 0; invalid = 0; rst = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    idle();
    addr = a;
    #1;
  endtask

  initial begin
    rst = 1; store = 0; edit = 0; invalid = 0; addr = 0; din = 0;
    cyc();
    // reset state
    rd(32'h0000_1234);
    chk("rst_hit",   {31'b0, hit},   0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_dirty", {31'b0, dirty}, 0);
    chk("rst_tag",   {10'b0, tag},   0);
    chk("rst_dout",  dout,           0);
    rd(32'hFFFF_FFFC);
    chk("rst_dout_hi", dout, 0);

    // 4-word line fill at index 0x23, tag 4
    for (int i = 0; i < 4; i++) begin
      idle(); store = 1; addr = 32'h0000_1230 + 32'(i*4); din = 32'hA0 + 32'(i);
      cyc();
    end
    rd(32'h0000_1238);
    chk("fill_hit",   {31'b0, hit},   1);
    chk("fill_dout",  dout,           32'hA2);
    chk("fill_valid", {31'b0, valid}, 1);
    chk("fill_dirty", {31'b0, dirty}, 0);
    chk("fill_tag",   {10'b0, tag},   32'h4);
    rd(32'h0000_123D);
    chk("fill_w3", dout, 32'hA3);

    // edit on hit; old value still visible before the edge
    idle(); edit = 1; addr = 32'h0000_1234; din = 32'hDEAD_BEEF; #1;
    chk("edit_nobypass", dout, 32'hA1);
    cyc();
    rd(32'h0000_1234);
    chk("edit_dout",  dout,           32'hDEAD_BEEF);
    chk("edit_dirty", {31'b0, dirty}, 1);
    chk("edit_hit",   {31'b0, hit},   1);
    rd(32'h0000_1230);
    chk("edit_w0_kept", dout, 32'hA0);

    // conflict miss: same index, tag 5
    rd(32'h0000_1634);
    chk("conf_hit",   {31'b0, hit},   0);
    chk("conf_valid", {31'b0, valid}, 1);
    chk("conf_dirty", {31'b0, dirty}, 1);
    chk("conf_tag",   {10'b0, tag},   32'h4);
    idle(); edit = 1; addr = 32'h0000_1634; din = 32'h5555_5555;
    cyc();
    rd(32'h0000_1634);
    chk("conf_edit_dout", dout, 32'hDEAD_BEEF);
    chk("conf_edit_tag",  {10'b0, tag}, 32'h4);
    rd(32'h0000_1244);
    chk("other_line_valid", {31'b0, valid}, 0);

    // invalidate
    idle(); invalid = 1; addr = 32'h0000_1230;
    cyc();
    rd(32'h0000_1234);
    chk("inv_valid", {31'b0, valid}, 0);
    chk("inv_dirty", {31'b0, dirty}, 0);
    chk("inv_hit",   {31'b0, hit},   0);
    chk("inv_data_kept", dout, 32'hDEAD_BEEF);
    chk("inv_tag_kept",  {10'b0, tag}, 32'h4);
    // store + invalid: invalid wins, data untouched
    idle(); store = 1; invalid = 1; addr = 32'h0000_1230; din = 32'h77;
    cyc();
    rd(32'h0000_1230);
    chk("si_valid", {31'b0, valid}, 0);
    chk("si_dout",  dout, 32'hA0);
    // edit on an invalid line with matching tag: no change
    idle(); edit = 1; addr = 32'h0000_1234; din = 32'h99;
    cyc();
    rd(32'h0000_1234);
    chk("edit_inv_dout",  dout, 32'hDEAD_BEEF);
    chk("edit_inv_dirty", {31'b0, dirty}, 0);

    // store + edit: store wins, line clean
    idle(); store = 1; edit = 1; addr = 32'h0000_2000; din = 32'h5;
    cyc();
    rd(32'h0000_2000);
    chk("se_valid", {31'b0, valid}, 1);
    chk("se_dirty", {31'b0, dirty}, 0);
    chk("se_dout",  dout, 32'h5);
    chk("se_hit",   {31'b0, hit}, 1);
    chk("se_tag",   {10'b0, tag}, 32'h8);

    // reset mid-fill, with store asserted on the reset edge
    idle(); store = 1; addr = 32'h0000_4000; din = 32'h1;
    cyc();
    store = 1; rst = 1; addr = 32'h0000_4004; din = 32'h2;
    cyc();
    rd(32'h0000_4000);
    chk("rmid_hit",  {31'b0, hit}, 0);
    chk("rmid_dout", dout, 0);
    rd(32'h0000_4004);
    chk("rmid_w1_valid", {31'b0, valid}, 0);
    chk("rmid_w1_dout",  dout, 0);
    rd(32'h0000_2000);
    chk("rmid_2000_valid", {31'b0, valid}, 0);
    chk("rmid_2000_dout",  dout, 0);
    rd(32'h0000_1234);
    chk("rmid_1234_dout", dout, 0);
    chk("rmid_1234_tag",  {10'b0, tag}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 Parameters: none; geometry is fixed by the requirements below.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 addr  input  32  byte address; tag=addr[31:10], index=addr[9:4], word=addr[3:2]; addr[1:0] ignored.
REQ-005 store  input  1  line-fill write strobe: write din into addressed word; line becomes valid and clean with new tag.
REQ-006 edit  input  1  processor write strobe: write din into addressed word on hit; line becomes dirty.
REQ-007 invalid  input  1  invalidate strobe for the addressed line.
REQ-008 din  input  32  write data for store/edit.
REQ-009 hit  output  1  addressed line valid AND stored tag == addr[31:10].
REQ-010 dout  output  32  stored word at (index, word), independent of hit.
REQ-011 valid  output  1  valid bit of the indexed line.
REQ-012 dirty  output  1  dirty bit of the indexed line.
REQ-013 tag  output  22  stored tag of the indexed line.

Function
REQ-014 Organisation: direct-mapped, 64 lines, 4 x 32-bit words per line (16-byte line, 1 KiB data); per line: valid, dirty, 22-bit tag.
REQ-015 hit, dout, valid, dirty and tag shall be purely combinational from addr and current state (zero-cycle read latency).
REQ-016 store=1 at a clock edge: data[index][word]<=din, tag[index]<=addr[31:10], valid[index]<=1, dirty[index]<=0, irrespective of prior hit.
REQ-017 edit=1 with hit=1 at a clock edge: data[index][word]<=din, dirty[index]<=1; tag and valid unchanged.
REQ-018 edit=1 with hit=0: no state change.
REQ-019 invalid=1 at a clock edge: valid[index]<=0, dirty[index]<=0; data and tag unchanged.
REQ-020 Simultaneous strobes: priority invalid > store > edit; only the highest-priority operation takes effect in that cycle.
REQ-021 No strobe asserted: state holds.
REQ-022 Effects of a write are visible on the outputs from the cycle after the edge (no write-through bypass in the same cycle).
REQ-023 Only the addressed word/line is modified by any operation; other words in the same line and other lines are unchanged.

Reset
REQ-024 rst=1 at a clock edge shall clear all valid bits, dirty bits, tags and data words to 0; rst overrides all strobes.
REQ-025 After reset, for any addr: hit=0, valid=0, dirty=0, tag=0, dout=0.
REQ-026 Reset asserted mid-sequence (e.g. during a 4-word fill) discards all partial contents; the next access misses.

Verification
REQ-027 Reset, addr=0x0000_1234 -> hit=0, valid=0, dirty=0, tag=0, dout=0.
REQ-028 Fill: store with addr=0x0000_1230/34/38/3C, din=0xA0..0xA3 -> read addr 0x0000_1238: hit=1, dout=0xA2, valid=1, dirty=0, tag=0x000004.
REQ-029 Edit on hit: edit addr=0x0000_1234, din=0xDEAD_BEEF -> next cycle dout=0xDEAD_BEEF, dirty=1, hit=1; word 0x1230 still 0xA0.
REQ-030 Conflict miss: addr=0x0000_1634 (same index, tag 0x000005) -> hit=0, valid=1, dirty=1, tag=0x000004; edit there leaves state unchanged.
REQ-031 Invalidate: invalid with addr=0x0000_1230 -> valid=0, dirty=0, hit=0 for 0x1234; then store+invalid same edge -> line stays invalid.
REQ-032 Priority/reset: store and edit same edge, addr=0x0000_2000, din=5 -> valid=1, dirty=0, dout=5; rst with store=1 -> all lines invalid, dout=0.
